// File: rtl/exec_sequencer.sv
// exec_sequencer: execution-stage sequencer that accepts one decoded operation
// at a time and drives a shared combinational ALU, using a second ALU pass to
// form the branch target. The result is handed to writeback/fetch over a
// valid/ready handshake.

module exec_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int ALU_OP_WIDTH   = 2,
    parameter int ALU_COMP_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      issue_valid,
    output logic                      issue_ready,
    input  logic [1:0]                issue_type,
    input  logic                      issue_sub,
    input  logic [2:0]                issue_funct3,
    input  logic [DATA_WIDTH-1:0]     issue_rs1,
    input  logic [DATA_WIDTH-1:0]     issue_rs2,
    input  logic [DATA_WIDTH-1:0]     issue_imm,
    input  logic [DATA_WIDTH-1:0]     issue_pc,
    output logic [DATA_WIDTH-1:0]     alu_din1,
    output logic [DATA_WIDTH-1:0]     alu_din2,
    output logic [ALU_OP_WIDTH-1:0]   alu_op,
    input  logic [DATA_WIDTH-1:0]     alu_dout,
    input  logic [ALU_COMP_WIDTH-1:0] alu_comp,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [DATA_WIDTH-1:0]     res_data,
    output logic                      res_is_branch,
    output logic                      res_taken
);

    // ALU operation encodings shared with the ALU
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_NOP = ALU_OP_WIDTH'(0);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD = ALU_OP_WIDTH'(1);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB = ALU_OP_WIDTH'(2);

    // Comparison flag bit positions
    localparam int ALU_COMP_EQ  = 0;
    localparam int ALU_COMP_LT  = 1;
    localparam int ALU_COMP_LTU = 2;

    // Operation types from decode
    localparam logic [1:0] TYPE_REG    = 2'd0;
    localparam logic [1:0] TYPE_IMM    = 2'd1;
    localparam logic [1:0] TYPE_BRANCH = 2'd2;
    localparam logic [1:0] TYPE_RSVD   = 2'd3;

    // Sequencer states
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXEC   = 2'd1;
    localparam logic [1:0] TARGET = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]            state_q,     state_d;
    logic [1:0]            type_q,      type_d;
    logic                  sub_q,       sub_d;
    logic [2:0]            funct3_q,    funct3_d;
    logic [DATA_WIDTH-1:0] rs1_q,       rs1_d;
    logic [DATA_WIDTH-1:0] rs2_q,       rs2_d;
    logic [DATA_WIDTH-1:0] imm_q,       imm_d;
    logic [DATA_WIDTH-1:0] pc_q,        pc_d;
    logic [DATA_WIDTH-1:0] res_data_q,  res_data_d;
    logic                  res_branch_q, res_branch_d;
    logic                  res_taken_q, res_taken_d;

    logic accept;
    logic branch_taken;

    assign issue_ready   = (state_q == IDLE) && !flush;
    assign accept        = issue_valid && issue_ready;
    assign res_valid     = (state_q == RESP);
    assign res_data      = res_data_q;
    assign res_is_branch = res_branch_q;
    assign res_taken     = res_taken_q;

    // Resolve branch direction from the flags of the rs1-rs2 subtraction
    always_comb begin
        branch_taken = 1'b0;
        case (funct3_q)
            3'b000:  branch_taken =  alu_comp[ALU_COMP_EQ];
            3'b001:  branch_taken = !alu_comp[ALU_COMP_EQ];
            3'b100:  branch_taken =  alu_comp[ALU_COMP_LT];
            3'b101:  branch_taken = !alu_comp[ALU_COMP_LT];
            3'b110:  branch_taken =  alu_comp[ALU_COMP_LTU];
            3'b111:  branch_taken = !alu_comp[ALU_COMP_LTU];
            default: branch_taken = 1'b0;
        endcase
    end

    // Drive the ALU only in the two compute states; park it at NOP/zero otherwise
    always_comb begin
        alu_din1 = '0;
        alu_din2 = '0;
        alu_op   = ALU_OP_NOP;
        if (state_q == EXEC) begin
            alu_din1 = rs1_q;
            case (type_q)
                TYPE_REG: begin
                    alu_din2 = rs2_q;
                    alu_op   = sub_q ? ALU_OP_SUB : ALU_OP_ADD;
                end
                TYPE_IMM: begin
                    alu_din2 = imm_q;
                    alu_op   = ALU_OP_ADD;
                end
                default: begin
                    alu_din2 = rs2_q;
                    alu_op   = ALU_OP_SUB;
                end
            endcase
        end else if (state_q == TARGET) begin
            alu_din1 = pc_q;
            alu_din2 = imm_q;
            alu_op   = ALU_OP_ADD;
        end
    end

    // Next-state, operand capture and result capture; flush overrides the state walk
    always_comb begin
        state_d      = state_q;
        type_d       = type_q;
        sub_d        = sub_q;
        funct3_d     = funct3_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        imm_d        = imm_q;
        pc_d         = pc_q;
        res_data_d   = res_data_q;
        res_branch_d = res_branch_q;
        res_taken_d  = res_taken_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    type_d       = issue_type;
                    sub_d        = issue_sub;
                    funct3_d     = issue_funct3;
                    rs1_d        = issue_rs1;
                    rs2_d        = issue_rs2;
                    imm_d        = issue_imm;
                    pc_d         = issue_pc;
                    res_data_d   = '0;
                    res_branch_d = 1'b0;
                    res_taken_d  = 1'b0;
                    state_d      = (issue_type == TYPE_RSVD) ? RESP : EXEC;
                end
            end
            EXEC: begin
                if (type_q == TYPE_BRANCH) begin
                    res_taken_d = branch_taken;
                    state_d     = TARGET;
                end else begin
                    res_data_d   = alu_dout;
                    res_branch_d = 1'b0;
                    res_taken_d  = 1'b0;
                    state_d      = RESP;
                end
            end
            TARGET: begin
                res_data_d   = alu_dout;
                res_branch_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
        end
    end

    // State and datapath registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            type_q       <= 2'd0;
            sub_q        <= 1'b0;
            funct3_q     <= 3'd0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            imm_q        <= '0;
            pc_q         <= '0;
            res_data_q   <= '0;
            res_branch_q <= 1'b0;
            res_taken_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            type_q       <= type_d;
            sub_q        <= sub_d;
            funct3_q     <= funct3_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            imm_q        <= imm_d;
            pc_q         <= pc_d;
            res_data_q   <= res_data_d;
            res_branch_q <= res_branch_d;
            res_taken_q  <= res_taken_d;
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: table-driven bench for exec_sequencer with a behavioural
// ALU, a result scoreboard and hand-written flush/reset/backpressure sequences.

module tb_exec_sequencer;

    localparam int DW = 32;
    localparam logic [1:0] OP_NOP = 2'd0;
    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          issue_valid = 1'b0;
    logic          issue_ready;
    logic [1:0]    issue_type = 2'd0;
    logic          issue_sub = 1'b0;
    logic [2:0]    issue_funct3 = 3'd0;
    logic [DW-1:0] issue_rs1 = '0;
    logic [DW-1:0] issue_rs2 = '0;
    logic [DW-1:0] issue_imm = '0;
    logic [DW-1:0] issue_pc = '0;
    logic [DW-1:0] alu_din1;
    logic [DW-1:0] alu_din2;
    logic [1:0]    alu_op;
    logic [DW-1:0] alu_dout;
    logic [2:0]    alu_comp;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [DW-1:0] res_data;
    logic          res_is_branch;
    logic          res_taken;

    typedef struct {
        logic [1:0]    typ;
        logic          sub;
        logic [2:0]    f3;
        logic [DW-1:0] rs1;
        logic [DW-1:0] rs2;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc;
        logic [DW-1:0] expData;
        logic          expBranch;
        logic          expTaken;
        logic [1:0]    expOp;
        int            expLat;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          br;
        logic          tk;
    } exp_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];
    exp_t sbQueue [$];

    int checks = 0;
    int failures = 0;

    exec_sequencer #(
        .DATA_WIDTH     (DW),
        .ALU_OP_WIDTH   (2),
        .ALU_COMP_WIDTH (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_type    (issue_type),
        .issue_sub     (issue_sub),
        .issue_funct3  (issue_funct3),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_imm     (issue_imm),
        .issue_pc      (issue_pc),
        .alu_din1      (alu_din1),
        .alu_din2      (alu_din2),
        .alu_op        (alu_op),
        .alu_dout      (alu_dout),
        .alu_comp      (alu_comp),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_is_branch (res_is_branch),
        .res_taken     (res_taken)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    // Behavioural combinational ALU the sequencer talks to
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_dout = alu_din1 + alu_din2;
            OP_SUB:  alu_dout = alu_din1 - alu_din2;
            default: alu_dout = '0;
        endcase
        alu_comp[0] = (alu_din1 == alu_din2);
        alu_comp[1] = ($signed(alu_din1) < $signed(alu_din2));
        alu_comp[2] = (alu_din1 < alu_din2);
    end

    // Absolute bound on simulation time so a stuck DUT cannot hang the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Offer one operation at a negedge; it is accepted at the following posedge
    task automatic applyStimulus(input int id, input vec_t v, input bit pushResult);
        exp_t e;
        @(negedge clk);
        issue_type   = v.typ;
        issue_sub    = v.sub;
        issue_funct3 = v.f3;
        issue_rs1    = v.rs1;
        issue_rs2    = v.rs2;
        issue_imm    = v.imm;
        issue_pc     = v.pc;
        issue_valid  = 1'b1;
        #1;
        checkOutput($sformatf("v%0d_issue_ready", id), 32'(issue_ready), 32'd1);
        @(posedge clk);
        if (pushResult) begin
            e.data = v.expData;
            e.br   = v.expBranch;
            e.tk   = v.expTaken;
            sbQueue.push_back(e);
        end
    endtask

    // Follow an accepted op to its result, compare against the scoreboard head
    task automatic waitResult(input int id, input int expLat, input logic [1:0] expOp);
        int   n;
        exp_t e;
        @(negedge clk);
        issue_valid = 1'b0;
        n = 1;
        checkOutput($sformatf("v%0d_alu_op", id), 32'(alu_op), 32'(expOp));
        while (!res_valid && n < 12) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) begin
            checkOutput($sformatf("v%0d_res_valid_timeout", id), 32'(res_valid), 32'd1);
            if (sbQueue.size() > 0) e = sbQueue.pop_front();
        end else begin
            checkOutput($sformatf("v%0d_latency", id), 32'(n), 32'(expLat));
            checkOutput($sformatf("v%0d_sb_nonempty", id), 32'(sbQueue.size() > 0), 32'd1);
            if (sbQueue.size() > 0) begin
                e = sbQueue.pop_front();
                checkOutput($sformatf("v%0d_res_data", id), res_data, e.data);
                checkOutput($sformatf("v%0d_res_is_branch", id), 32'(res_is_branch), 32'(e.br));
                checkOutput($sformatf("v%0d_res_taken", id), 32'(res_taken), 32'(e.tk));
            end
            if (res_ready) begin
                @(negedge clk);
                checkOutput($sformatf("v%0d_valid_drop", id), 32'(res_valid), 32'd0);
                checkOutput($sformatf("v%0d_ready_back", id), 32'(issue_ready), 32'd1);
            end
        end
    endtask

    initial begin : main
        vec_t bp;
        bit   sawValid;

        //          typ   sub  f3      rs1           rs2           imm           pc            expData       br tk op      lat
        vecs[0]  = '{2'd0, 1'b0, 3'b000, 32'd5,        32'd7,        32'd0,        32'd0,        32'd12,       1'b0, 1'b0, OP_ADD, 2};
        vecs[1]  = '{2'd0, 1'b1, 3'b000, 32'd0,        32'd1,        32'd0,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, OP_SUB, 2};
        vecs[2]  = '{2'd1, 1'b0, 3'b000, 32'h10,       32'd0,        32'hFFFFFFF0, 32'd0,        32'd0,        1'b0, 1'b0, OP_ADD, 2};
        vecs[3]  = '{2'd2, 1'b0, 3'b100, 32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,      32'h120,      1'b1, 1'b1, OP_SUB, 3};
        vecs[4]  = '{2'd2, 1'b0, 3'b110, 32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,      32'h120,      1'b1, 1'b0, OP_SUB, 3};
        vecs[5]  = '{2'd2, 1'b0, 3'b000, 32'd9,        32'd9,        32'hFFFFFFFC, 32'h200,      32'h1FC,      1'b1, 1'b1, OP_SUB, 3};
        vecs[6]  = '{2'd2, 1'b0, 3'b001, 32'd9,        32'd9,        32'hFFFFFFFC, 32'h200,      32'h1FC,      1'b1, 1'b0, OP_SUB, 3};
        vecs[7]  = '{2'd2, 1'b0, 3'b101, 32'd3,        32'hFFFFFFFE, 32'h20,       32'hFFFFFFF0, 32'h10,       1'b1, 1'b1, OP_SUB, 3};
        vecs[8]  = '{2'd2, 1'b0, 3'b111, 32'd3,        32'hFFFFFFFE, 32'h20,       32'hFFFFFFF0, 32'h10,       1'b1, 1'b0, OP_SUB, 3};
        vecs[9]  = '{2'd2, 1'b0, 3'b010, 32'd1,        32'd1,        32'h8,        32'h40,       32'h48,       1'b1, 1'b0, OP_SUB, 3};
        vecs[10] = '{2'd3, 1'b0, 3'b000, 32'd5,        32'd7,        32'd0,        32'd0,        32'd0,        1'b0, 1'b0, OP_NOP, 1};
        vecs[11] = '{2'd2, 1'b0, 3'b100, 32'd1,        32'hFFFFFFFF, 32'h4,        32'h0,        32'h4,        1'b1, 1'b0, OP_SUB, 3};
        vecs[12] = '{2'd2, 1'b0, 3'b001, 32'd1,        32'd2,        32'h10,       32'h1000,     32'h1010,     1'b1, 1'b1, OP_SUB, 3};
        vecs[13] = '{2'd2, 1'b0, 3'b111, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFF8, 32'h8,        32'h0,        1'b1, 1'b1, OP_SUB, 3};
        vecs[14] = '{2'd1, 1'b1, 3'b000, 32'd3,        32'd0,        32'd4,        32'd0,        32'd7,        1'b0, 1'b0, OP_ADD, 2};
        vecs[15] = '{2'd0, 1'b0, 3'b000, 32'd100,      32'd1,        32'd50,       32'd0,        32'd101,      1'b0, 1'b0, OP_ADD, 2};
        vecs[16] = '{2'd2, 1'b0, 3'b011, 32'd5,        32'd5,        32'd0,        32'h30,       32'h30,       1'b1, 1'b0, OP_SUB, 3};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
        checkOutput("rst_res_data", res_data, 32'd0);
        checkOutput("rst_res_is_branch", 32'(res_is_branch), 32'd0);
        checkOutput("rst_res_taken", 32'(res_taken), 32'd0);
        checkOutput("rst_alu_op", 32'(alu_op), 32'(OP_NOP));
        checkOutput("rst_alu_din1", alu_din1, 32'd0);
        checkOutput("rst_alu_din2", alu_din2, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("idle_issue_ready", 32'(issue_ready), 32'd1);

        // Table-driven operations with the consumer always ready
        res_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(i, vecs[i], 1'b1);
            waitResult(i, vecs[i].expLat, vecs[i].expOp);
        end

        // Backpressure: result must hold while the consumer stalls
        bp = '{2'd1, 1'b0, 3'b000, 32'd3, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd2, 1'b0, 1'b0, OP_ADD, 2};
        res_ready = 1'b0;
        applyStimulus(100, bp, 1'b1);
        waitResult(100, bp.expLat, bp.expOp);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("bp%0d_res_valid", k), 32'(res_valid), 32'd1);
            checkOutput($sformatf("bp%0d_res_data", k), res_data, 32'd2);
            checkOutput($sformatf("bp%0d_issue_ready", k), 32'(issue_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_valid", 32'(res_valid), 32'd0);
        checkOutput("bp_release_ready", 32'(issue_ready), 32'd1);

        // Flush while the branch target is being computed
        applyStimulus(101, vecs[5], 1'b0);
        @(negedge clk);
        issue_valid = 1'b0;
        @(negedge clk);
        checkOutput("fl_target_alu_op", 32'(alu_op), 32'(OP_ADD));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        checkOutput("fl_target_issue_ready", 32'(issue_ready), 32'd1);
        checkOutput("fl_target_res_valid", 32'(res_valid), 32'd0);
        sawValid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (res_valid) sawValid = 1'b1;
        end
        checkOutput("fl_target_no_result", 32'(sawValid), 32'd0);

        // Flush coinciding with an offer in IDLE: nothing is accepted
        @(negedge clk);
        issue_type  = 2'd0;
        issue_sub   = 1'b0;
        issue_rs1   = 32'd1;
        issue_rs2   = 32'd1;
        issue_valid = 1'b1;
        flush       = 1'b1;
        #1;
        checkOutput("fl_idle_issue_ready", 32'(issue_ready), 32'd0);
        @(negedge clk);
        issue_valid = 1'b0;
        flush       = 1'b0;
        #1;
        checkOutput("fl_idle_alu_op", 32'(alu_op), 32'(OP_NOP));
        checkOutput("fl_idle_res_valid0", 32'(res_valid), 32'd0);
        @(negedge clk);
        checkOutput("fl_idle_res_valid1", 32'(res_valid), 32'd0);

        // Asynchronous reset in the middle of EXEC, then recovery
        applyStimulus(102, vecs[0], 1'b0);
        @(negedge clk);
        issue_valid = 1'b0;
        checkOutput("ar_exec_alu_op", 32'(alu_op), 32'(OP_ADD));
        #2;
        rst = 1'b0;
        #1;
        checkOutput("ar_res_valid", 32'(res_valid), 32'd0);
        checkOutput("ar_alu_op", 32'(alu_op), 32'(OP_NOP));
        checkOutput("ar_alu_din1", alu_din1, 32'd0);
        checkOutput("ar_res_data", res_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(103, vecs[15], 1'b1);
        waitResult(103, vecs[15].expLat, vecs[15].expOp);

        checkOutput("sb_empty", 32'(sbQueue.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
